// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared codes for the EX stage (ALUOp, ALU control, funct, mul FSM, forwarding).
package ex_stage_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_SUB = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_MUL
    } alu_ctrl_e;

    localparam logic [9:0] F_ADD = 10'b0000000_000;
    localparam logic [9:0] F_SUB = 10'b0100000_000;
    localparam logic [9:0] F_AND = 10'b0000000_111;
    localparam logic [9:0] F_OR  = 10'b0000000_110;
    localparam logic [9:0] F_MUL = 10'b0000001_000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } mul_state_e;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_e;

    // EX/MEM beats MEM/WB; a destination of x0 never forwards.
    function automatic fwd_e fwd_sel(input logic exmem_we, input logic [4:0] exmem_rd,
                                     input logic memwb_we, input logic [4:0] memwb_rd,
                                     input logic [4:0] rs);
        return (exmem_we && exmem_rd != 5'd0 && exmem_rd == rs) ? FWD_EXMEM :
               (memwb_we && memwb_rd != 5'd0 && memwb_rd == rs) ? FWD_MEMWB : FWD_REG;
    endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// ex_stage_mul_iter: iterative shift-add multiplier, one product bit per cycle over XLEN cycles.
module ex_stage_mul_iter
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);
    localparam int CW = $clog2(XLEN) + 1;

    mul_state_e      r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_a, r_b, r_prod;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_IDLE) ? (i_start ? S_BUSY : S_IDLE) :
                 (r_state == S_BUSY) ? ((r_cnt == CW'(XLEN - 1)) ? S_DONE : S_BUSY) : S_IDLE;
    end

    // Only the low XLEN bits of the product are kept, so shifting A out the top is harmless.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_cnt  <= '0;
            r_a    <= i_a;
            r_b    <= i_b;
            r_prod <= '0;
        end else if (r_state == S_BUSY) begin
            r_cnt  <= r_cnt + 1'b1;
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_prod <= r_prod + (r_b[0] ? r_a : '0);
        end
    end

    assign o_stall   = reset && (r_state == S_BUSY || (r_state == S_IDLE && i_start));
    assign o_done    = (r_state == S_DONE);
    assign o_product = r_prod;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU decode/execute with iterative multiply, and the EX/MEM register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite_in,
    input  logic            MemtoReg_in,
    input  logic            MemRead_in,
    input  logic            MemWrite_in,
    input  logic            ALUSrc_in,
    input  logic [1:0]      ALUOp_in,
    input  logic [9:0]      funct_in,
    input  logic [XLEN-1:0] reg_read_data_1_in,
    input  logic [XLEN-1:0] reg_read_data_2_in,
    input  logic [XLEN-1:0] immi_sign_extended_in,
    input  logic [4:0]      RegisterRs1_in,
    input  logic [4:0]      RegisterRs2_in,
    input  logic [4:0]      RegisterRd_in,
    input  logic            MEM_WB_RegWrite,
    input  logic [4:0]      MEM_WB_RegisterRd,
    input  logic [XLEN-1:0] MEM_WB_write_data,
    output logic            ex_stall,
    output logic            RegWrite_out,
    output logic            MemtoReg_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic [XLEN-1:0] ALU_result_out,
    output logic [XLEN-1:0] mem_write_data_out,
    output logic [4:0]      RegisterRd_out
);
    fwd_e            w_fwd_a, w_fwd_b;
    alu_ctrl_e       w_alu_ctrl;
    logic [XLEN-1:0] w_a, w_b, w_op_b, w_alu, w_product;
    logic            w_is_mul, w_mul_done, w_bubble;

    assign w_fwd_a = fwd_sel(RegWrite_out, RegisterRd_out, MEM_WB_RegWrite, MEM_WB_RegisterRd, RegisterRs1_in);
    assign w_fwd_b = fwd_sel(RegWrite_out, RegisterRd_out, MEM_WB_RegWrite, MEM_WB_RegisterRd, RegisterRs2_in);

    assign w_a = (w_fwd_a == FWD_EXMEM) ? ALU_result_out :
                 (w_fwd_a == FWD_MEMWB) ? MEM_WB_write_data : reg_read_data_1_in;
    assign w_b = (w_fwd_b == FWD_EXMEM) ? ALU_result_out :
                 (w_fwd_b == FWD_MEMWB) ? MEM_WB_write_data : reg_read_data_2_in;
    assign w_op_b = ALUSrc_in ? immi_sign_extended_in : w_b;

    // I-type ops all resolve to add; unknown R-type functs also fall back to add.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_alu_ctrl = (ALUOp_in == ALUOP_SUB) ? ALU_SUB :
                     (ALUOp_in != ALUOP_R)   ? ALU_ADD :
                     (funct_in == F_SUB)     ? ALU_SUB :
                     (funct_in == F_AND)     ? ALU_AND :
                     (funct_in == F_OR)      ? ALU_OR  :
                     (funct_in == F_MUL)     ? ALU_MUL : ALU_ADD;
    end

    assign w_alu = (w_alu_ctrl == ALU_SUB) ? w_a - w_op_b :
                   (w_alu_ctrl == ALU_AND) ? w_a & w_op_b :
                   (w_alu_ctrl == ALU_OR)  ? w_a | w_op_b : w_a + w_op_b;

    assign w_is_mul = (w_alu_ctrl == ALU_MUL);
    assign w_bubble = w_is_mul && !w_mul_done;

    ex_stage_mul_iter #(.XLEN(XLEN)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_is_mul),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_stall   (ex_stall),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWrite_out       <= 1'b0;
            MemtoReg_out       <= 1'b0;
            MemRead_out        <= 1'b0;
            MemWrite_out       <= 1'b0;
            ALU_result_out     <= '0;
            mem_write_data_out <= '0;
            RegisterRd_out     <= '0;
        end else begin
            RegWrite_out       <= RegWrite_in && !w_bubble;
            MemtoReg_out       <= MemtoReg_in && !w_bubble;
            MemRead_out        <= MemRead_in && !w_bubble;
            MemWrite_out       <= MemWrite_in && !w_bubble;
            ALU_result_out     <= w_mul_done ? w_product : w_alu;
            mem_write_data_out <= w_b;
            RegisterRd_out     <= RegisterRd_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage covering forwarding, ALU ops, multiply timing and reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int XLEN = 32;
    typedef logic [72:0] vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  fn;
        logic        src;
        logic [3:0]  ctl;
        logic [31:0] d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] res, wd;
    } case_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in, ALUSrc_in;
    logic [1:0] ALUOp_in;
    logic [9:0] funct_in;
    logic [31:0] reg_read_data_1_in, reg_read_data_2_in, immi_sign_extended_in;
    logic [4:0] RegisterRs1_in, RegisterRs2_in, RegisterRd_in;
    logic MEM_WB_RegWrite;
    logic [4:0] MEM_WB_RegisterRd;
    logic [31:0] MEM_WB_write_data;
    logic ex_stall, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out;
    logic [31:0] ALU_result_out, mem_write_data_out;
    logic [4:0] RegisterRd_out;

    vec_t sb[$];
    int n_tests = 0;
    int n_fail = 0;

    ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in), .ALUOp_in(ALUOp_in), .funct_in(funct_in),
        .reg_read_data_1_in(reg_read_data_1_in), .reg_read_data_2_in(reg_read_data_2_in),
        .immi_sign_extended_in(immi_sign_extended_in),
        .RegisterRs1_in(RegisterRs1_in), .RegisterRs2_in(RegisterRs2_in), .RegisterRd_in(RegisterRd_in),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_RegisterRd(MEM_WB_RegisterRd),
        .MEM_WB_write_data(MEM_WB_write_data),
        .ex_stall(ex_stall), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
        .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .ALU_result_out(ALU_result_out),
        .mem_write_data_out(mem_write_data_out), .RegisterRd_out(RegisterRd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [3:0] ctl, input logic [4:0] rd,
                                input logic [31:0] res, input logic [31:0] wd);
        return {ctl, rd, res, wd};
    endfunction

    function automatic vec_t obs();
        return {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, RegisterRd_out,
                ALU_result_out, mem_write_data_out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [9:0] fn, input logic src,
                         input logic [3:0] ctl, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
        ALUOp_in = op;
        funct_in = fn;
        ALUSrc_in = src;
        {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in} = ctl;
        reg_read_data_1_in = d1;
        reg_read_data_2_in = d2;
        immi_sign_extended_in = imm;
        RegisterRs1_in = rs1;
        RegisterRs2_in = rs2;
        RegisterRd_in = rd;
    endtask

    task automatic test_reset();
        vec_t e;
        reset = 1'b0;
        MEM_WB_RegWrite = 1'b1;
        MEM_WB_RegisterRd = 5'd1;
        MEM_WB_write_data = 32'h1234;
        drive(2'b10, F_MUL, 1'b0, 4'b1111, 32'd9, 32'd8, 32'd7, 5'd1, 5'd2, 5'd3);
        step();
        step();
        n_tests++;
        if (obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        n_tests++;
        if (ex_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b expected 0", ex_stall);
        end
        reset = 1'b1;
        MEM_WB_RegWrite = 1'b0;
        drive(2'b10, F_ADD, 1'b0, 4'b1000, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
        sb.push_back(mk(4'b1000, 5'd3, 32'd12, 32'd7));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e || ex_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL add_after_reset: got %h stall %b expected %h", obs(), ex_stall, e);
        end
    endtask

    task automatic test_forwarding();
        vec_t e;
        drive(2'b11, F_ADD, 1'b1, 4'b1000, 32'd0, 32'd0, 32'd100, 5'd0, 5'd0, 5'd4);
        sb.push_back(mk(4'b1000, 5'd4, 32'd100, 32'd0));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL fwd_setup: got %h expected %h", obs(), e);
        end
        MEM_WB_RegWrite = 1'b1;
        MEM_WB_RegisterRd = 5'd4;
        MEM_WB_write_data = 32'd200;
        drive(2'b00, F_ADD, 1'b0, 4'b1000, 32'd0, 32'd0, 32'd0, 5'd4, 5'd0, 5'd5);
        sb.push_back(mk(4'b1000, 5'd5, 32'd100, 32'd0));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL fwd_double_hazard: got %h expected %h", obs(), e);
        end
        drive(2'b00, F_ADD, 1'b0, 4'b1000, 32'd0, 32'd0, 32'd0, 5'd4, 5'd0, 5'd6);
        sb.push_back(mk(4'b1000, 5'd6, 32'd200, 32'd0));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL fwd_memwb: got %h expected %h", obs(), e);
        end
        drive(2'b01, F_ADD, 1'b0, 4'b1000, 32'd1000, 32'd0, 32'd0, 5'd9, 5'd6, 5'd7);
        sb.push_back(mk(4'b1000, 5'd7, 32'd800, 32'd200));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL fwd_exmem_rs2: got %h expected %h", obs(), e);
        end
    endtask

    task automatic test_x0_guard();
        vec_t e;
        MEM_WB_RegWrite = 1'b1;
        MEM_WB_RegisterRd = 5'd0;
        MEM_WB_write_data = 32'hDEAD;
        drive(2'b11, F_ADD, 1'b1, 4'b1000, 32'd0, 32'd0, 32'd3, 5'd0, 5'd0, 5'd8);
        sb.push_back(mk(4'b1000, 5'd8, 32'd3, 32'd0));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL x0_memwb: got %h expected %h", obs(), e);
        end
        drive(2'b11, F_ADD, 1'b1, 4'b1000, 32'd0, 32'd0, 32'h77, 5'd0, 5'd0, 5'd0);
        sb.push_back(mk(4'b1000, 5'd0, 32'h77, 32'd0));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL x0_write: got %h expected %h", obs(), e);
        end
        drive(2'b10, F_ADD, 1'b0, 4'b1000, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9);
        sb.push_back(mk(4'b1000, 5'd9, 32'd0, 32'd0));
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL x0_exmem: got %h expected %h", obs(), e);
        end
        MEM_WB_RegWrite = 1'b0;
    endtask

    task automatic test_alu_ops();
        case_t t[9];
        vec_t e;
        t[0] = '{2'b10, F_AND, 1'b0, 4'b1000, 32'hF0F0, 32'hFF00, 32'h0, 5'd10, 5'd11, 5'd15, 32'hF000, 32'hFF00};
        t[1] = '{2'b10, F_OR, 1'b0, 4'b1000, 32'hF0F0, 32'hFF00, 32'h0, 5'd10, 5'd11, 5'd16, 32'hFFF0, 32'hFF00};
        t[2] = '{2'b10, 10'b0000000_001, 1'b0, 4'b1000, 32'd3, 32'd4, 32'h0, 5'd10, 5'd11, 5'd17, 32'd7, 32'd4};
        t[3] = '{2'b11, 10'b0000000_111, 1'b1, 4'b1000, 32'h10, 32'h0, 32'h5, 5'd10, 5'd0, 5'd18, 32'h15, 32'h0};
        t[4] = '{2'b10, F_SUB, 1'b0, 4'b1000, 32'd0, 32'd1, 32'h0, 5'd10, 5'd11, 5'd19, 32'hFFFFFFFF, 32'd1};
        t[5] = '{2'b11, F_ADD, 1'b1, 4'b1000, 32'd0, 32'd0, 32'h55, 5'd0, 5'd0, 5'd12, 32'h55, 32'h0};
        t[6] = '{2'b00, F_ADD, 1'b1, 4'b0001, 32'h100, 32'h0, 32'h8, 5'd13, 5'd12, 5'd0, 32'h108, 32'h55};
        t[7] = '{2'b00, F_ADD, 1'b1, 4'b1110, 32'h100, 32'h0, 32'h4, 5'd13, 5'd0, 5'd14, 32'h104, 32'h0};
        t[8] = '{2'b01, F_ADD, 1'b0, 4'b1000, 32'd10, 32'd3, 32'h0, 5'd20, 5'd21, 5'd22, 32'd7, 32'd3};
        for (int i = 0; i < 9; i++) begin
            drive(t[i].op, t[i].fn, t[i].src, t[i].ctl, t[i].d1, t[i].d2, t[i].imm,
                  t[i].rs1, t[i].rs2, t[i].rd);
            sb.push_back(mk(t[i].ctl, t[i].rd, t[i].res, t[i].wd));
            step();
            e = sb.pop_front();
            n_tests++;
            if (obs() !== e || ex_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_case%0d: got %h stall %b expected %h", i, obs(), ex_stall, e);
            end
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        vec_t e;
        int stalls;
        bit bad;
        drive(2'b10, F_MUL, 1'b0, 4'b1000, a, b, 32'h0, 5'd20, 5'd21, rd);
        sb.push_back(mk(4'b1000, rd, a * b, b));
        #1;
        stalls = 0;
        bad = 1'b0;
        for (int i = 0; i < 40 && ex_stall === 1'b1; i++) begin
            stalls++;
            step();
            if ({RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out} !== 4'b0000) bad = 1'b1;
        end
        n_tests++;
        if (stalls != XLEN + 1) begin
            n_fail++;
            $display("FAIL mul_stall_len rd%0d: got %0d cycles expected %0d", rd, stalls, XLEN + 1);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL mul_bubble rd%0d: got control bits set expected 0", rd);
        end
        step();
        e = sb.pop_front();
        n_tests++;
        if (obs() !== e) begin
            n_fail++;
            $display("FAIL mul_result rd%0d: got %h expected %h", rd, obs(), e);
        end
    endtask

    task automatic test_mul();
        run_mul(32'd7, 32'd6, 5'd23);
    endtask

    task automatic test_back_to_back();
        run_mul(32'hFFFFFFFF, 32'd2, 5'd24);
        run_mul(32'h12345, 32'h100, 5'd25);
    endtask

    task automatic test_reset_mid_mul();
        drive(2'b10, F_MUL, 1'b0, 4'b1000, 32'd5, 32'd5, 32'h0, 5'd20, 5'd21, 5'd26);
        step();
        repeat (10) step();
        reset = 1'b0;
        drive(2'b10, F_MUL, 1'b0, 4'b1000, 32'd3, 32'd3, 32'h0, 5'd20, 5'd21, 5'd27);
        step();
        n_tests++;
        if (obs() !== '0 || ex_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got %h stall %b expected 0 stall 0", obs(), ex_stall);
        end
        reset = 1'b1;
        run_mul(32'd3, 32'd3, 5'd27);
    endtask

    initial begin
        drive(2'b00, F_ADD, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        MEM_WB_RegWrite = 1'b0;
        MEM_WB_RegisterRd = 5'd0;
        MEM_WB_write_data = 32'h0;
        test_reset();
        test_forwarding();
        test_x0_guard();
        test_alu_ops();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        drive(2'b00, F_ADD, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
